chimera_clu_clk_ctrl: RTL and testbench



---
 rtl/chimera_clk_ctrl_pkg.sv | 32 +++
 rtl/chimera_clu_clk_fsm.sv | 160 ++++++++++++++++
 rtl/chimera_clu_clk_ctrl.sv | 60 ++++++
 tb/tb_chimera_clu_clk_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chimera_clk_ctrl_pkg.sv
// Package for the per-cluster clock-gate sequencer.
// Provides the channel state encoding, default timing constants and the
// helper that sizes the per-channel down-counters.
package chimera_clk_ctrl_pkg;

  typedef enum logic [2:0] {
    CLU_RUN     = 3'd0,
    CLU_ISOLATE = 3'd1,
    CLU_SETTLE  = 3'd2,
    CLU_GATED   = 3'd3,
    CLU_WAKE    = 3'd4
  } clu_clk_state_e;

  localparam int unsigned DefaultGateDelay     = 4;
  localparam int unsigned DefaultWakeCycles    = 8;
  localparam int unsigned DefaultTimeoutCycles = 1024;

  // Width needed to hold the largest load value; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned gate_delay,
                                            input int unsigned wake_cycles,
                                            input int unsigned timeout_cycles);
    int unsigned m;
    int unsigned w;
    m = gate_delay;
    if (wake_cycles > m) m = wake_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    w = $clog2(m + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/chimera_clu_clk_fsm.sv
// One cluster channel of the clock-gate sequencer.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   gate_req_i      level request, 1 = gate the cluster clock
//   idle_i          cluster has no outstanding transactions
//   clk_en_o        enable to the clock-gating cell
//   isolate_o       blocks new AXI traffic to/from the cluster
//   state_o         current FSM state (status/debug)
//   busy_o          channel is in a transitional state
//   timeout_o       sticky drain-timeout flag
// Optional macro: CHIMERA_CLK_CTRL_TIMEOUT_EN adds the drain timeout.
//
// All outputs decode the registered state; inputs only affect next state.
module chimera_clu_clk_fsm
  import chimera_clk_ctrl_pkg::*;
#(
  parameter int unsigned GateDelay     = DefaultGateDelay,
  parameter int unsigned WakeCycles    = DefaultWakeCycles,
  parameter int unsigned TimeoutCycles = DefaultTimeoutCycles,
  parameter bit          ResetGated    = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           gate_req_i,
  input  logic           idle_i,
  output logic           clk_en_o,
  output logic           isolate_o,
  output clu_clk_state_e state_o,
  output logic           busy_o,
  output logic           timeout_o
);

  localparam int unsigned CntW = cnt_width(GateDelay, WakeCycles, TimeoutCycles);
  localparam int unsigned GateLoadI = (GateDelay > 0) ? GateDelay - 1 : 0;
  localparam int unsigned WakeLoadI = (WakeCycles > 0) ? WakeCycles - 1 : 0;
  localparam logic [CntW-1:0] GateLoad = CntW'(GateLoadI);
  localparam logic [CntW-1:0] WakeLoad = CntW'(WakeLoadI);
  localparam clu_clk_state_e ResetState = ResetGated ? CLU_GATED : CLU_RUN;

  clu_clk_state_e  r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            w_tmo_expired;
  logic            w_tmo_set;
  logic            w_leave_gated;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tmo_set     = 1'b0;
    w_leave_gated = 1'b0;
    case (r_state)
      CLU_RUN: begin
        if (gate_req_i) begin
          w_state_nxt = CLU_ISOLATE;
          w_cnt_nxt   = '0;
        end
      end
      CLU_ISOLATE: begin
        if (!gate_req_i) begin
          w_state_nxt = CLU_RUN;
        end else if (idle_i) begin
          if (GateDelay == 0) begin
            w_state_nxt = CLU_GATED;
          end else begin
            w_state_nxt = CLU_SETTLE;
            w_cnt_nxt   = GateLoad;
          end
        end else if (w_tmo_expired) begin
          w_state_nxt = CLU_GATED;
          w_tmo_set   = 1'b1;
        end
      end
      CLU_SETTLE: begin
        // Normal gating wins over a simultaneous timeout so the flag only
        // marks channels that were forced.
        if (!gate_req_i) begin
          w_state_nxt = CLU_RUN;
        end else if (idle_i && (r_cnt == '0)) begin
          w_state_nxt = CLU_GATED;
        end else if (w_tmo_expired) begin
          w_state_nxt = CLU_GATED;
          w_tmo_set   = 1'b1;
        end else if (!idle_i) begin
          w_state_nxt = CLU_ISOLATE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end
      end
      CLU_GATED: begin
        if (!gate_req_i) begin
          w_leave_gated = 1'b1;
          if (WakeCycles == 0) begin
            w_state_nxt = CLU_RUN;
          end else begin
            w_state_nxt = CLU_WAKE;
            w_cnt_nxt   = WakeLoad;
          end
        end
      end
      CLU_WAKE: begin
        // Wake always runs to completion; a held request is served from RUN.
        if (r_cnt == '0) w_state_nxt = CLU_RUN;
        else             w_cnt_nxt   = r_cnt - CntW'(1);
      end
      default: begin
        w_state_nxt = CLU_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ResetState;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef CHIMERA_CLK_CTRL_TIMEOUT_EN
  localparam int unsigned TmoLoadI = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
  localparam logic [CntW-1:0] TmoLoad = CntW'(TmoLoadI);

  logic [CntW-1:0] r_tcnt;
  logic            r_timeout;

  // Loaded only when a drain starts from RUN, so an idle line that keeps
  // bouncing between ISOLATE and SETTLE cannot postpone the timeout forever.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state == CLU_RUN) && (w_state_nxt == CLU_ISOLATE)) begin
        r_tcnt <= TmoLoad;
      end else if (((r_state == CLU_ISOLATE) || (r_state == CLU_SETTLE)) &&
                   (r_tcnt != '0)) begin
        r_tcnt <= r_tcnt - CntW'(1);
      end
      if (w_tmo_set)          r_timeout <= 1'b1;
      else if (w_leave_gated) r_timeout <= 1'b0;
    end
  end

  assign w_tmo_expired = (r_tcnt == '0);
  assign timeout_o     = r_timeout;
`else
  assign w_tmo_expired = 1'b0;
  assign timeout_o     = 1'b0;
`endif

  assign state_o   = r_state;
  assign clk_en_o  = (r_state != CLU_GATED);
  assign isolate_o = (r_state != CLU_RUN);
  assign busy_o    = (r_state != CLU_RUN) && (r_state != CLU_GATED);

endmodule

// File: rtl/chimera_clu_clk_ctrl.sv
// Per-cluster clock-gate sequencer: isolate, drain, gate and wake each
// cluster safely instead of driving the clock gate straight from a register.
// Ports:
//   clk_i, rst_ni   SoC clock, asynchronous active-low reset
//   gate_req_i      per-channel level gate request
//   idle_i          per-channel cluster idle indication
//   clk_en_o        per-channel enable to tc_clk_gating
//   isolate_o       per-channel AXI isolation
//   state_o         per-channel 3-bit FSM state
//   busy_o          any channel in a transitional state
//   timeout_o       per-channel sticky drain-timeout flag
// Optional macro: CHIMERA_CLK_CTRL_TIMEOUT_EN (drain timeout; else tied 0).
module chimera_clu_clk_ctrl
  import chimera_clk_ctrl_pkg::*;
#(
  parameter int unsigned                  NumClusters   = 5,
  parameter int unsigned                  GateDelay     = DefaultGateDelay,
  parameter int unsigned                  WakeCycles    = DefaultWakeCycles,
  parameter logic [NumClusters-1:0]       ResetGated    = '0,
  parameter int unsigned                  TimeoutCycles = DefaultTimeoutCycles
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumClusters-1:0]      gate_req_i,
  input  logic [NumClusters-1:0]      idle_i,
  output logic [NumClusters-1:0]      clk_en_o,
  output logic [NumClusters-1:0]      isolate_o,
  output logic [NumClusters-1:0][2:0] state_o,
  output logic                        busy_o,
  output logic [NumClusters-1:0]      timeout_o
);

  logic [NumClusters-1:0] w_busy;

  for (genvar i = 0; i < NumClusters; i++) begin : g_chan
    clu_clk_state_e w_state;

    chimera_clu_clk_fsm #(
      .GateDelay     (GateDelay),
      .WakeCycles    (WakeCycles),
      .TimeoutCycles (TimeoutCycles),
      .ResetGated    (ResetGated[i])
    ) u_fsm (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .gate_req_i (gate_req_i[i]),
      .idle_i     (idle_i[i]),
      .clk_en_o   (clk_en_o[i]),
      .isolate_o  (isolate_o[i]),
      .state_o    (w_state),
      .busy_o     (w_busy[i]),
      .timeout_o  (timeout_o[i])
    );

    assign state_o[i] = w_state;
  end

  assign busy_o = |w_busy;

endmodule

// File: tb/tb_chimera_clu_clk_ctrl.sv
// Directed bench for chimera_clu_clk_ctrl with a cycle-tagged scoreboard.
module tb_chimera_clu_clk_ctrl;

  localparam int N = 5;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [N-1:0]      gate_req;
  logic [N-1:0]      idle;
  logic [N-1:0]      clk_en;
  logic [N-1:0]      iso;
  logic [N-1:0][2:0] state;
  logic              busy;
  logic [N-1:0]      tmo;

  chimera_clu_clk_ctrl #(
    .NumClusters   (N),
    .GateDelay     (4),
    .WakeCycles    (8),
    .ResetGated    (5'b10010),
    .TimeoutCycles (16)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .gate_req_i (gate_req),
    .idle_i     (idle),
    .clk_en_o   (clk_en),
    .isolate_o  (iso),
    .state_o    (state),
    .busy_o     (busy),
    .timeout_o  (tmo)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  localparam int K_CLKEN = 0, K_ISO = 1, K_STATE = 2, K_BUSY = 3,
                 K_TMO = 4, K_CLKEN_V = 5, K_ISO_V = 6;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  kind;
    logic [3:0]  ch;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic exp_push(input int unsigned at, input int kind, input int ch,
                          input logic [15:0] val);
    exp_t e;
    e.cyc  = at;
    e.kind = kind[3:0];
    e.ch   = ch[3:0];
    e.val  = val;
    exp_q.push_back(e);
  endtask

  function automatic logic [15:0] actual(input int kind, input int ch);
    case (kind)
      K_CLKEN:   return 16'(clk_en[ch]);
      K_ISO:     return 16'(iso[ch]);
      K_STATE:   return 16'(state[ch]);
      K_BUSY:    return 16'(busy);
      K_TMO:     return 16'(tmo[ch]);
      K_CLKEN_V: return 16'(clk_en);
      K_ISO_V:   return 16'(iso);
      default:   return 16'hdead;
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_CLKEN:   return "clk_en";
      K_ISO:     return "isolate";
      K_STATE:   return "state";
      K_BUSY:    return "busy";
      K_TMO:     return "timeout";
      K_CLKEN_V: return "clk_en_vec";
      K_ISO_V:   return "isolate_vec";
      default:   return "unknown";
    endcase
  endfunction

  // Monitor: on every falling edge compare all entries tagged for this cycle.
  always @(negedge clk) begin
    int n;
    logic [15:0] got;
    n = exp_q.size();
    for (int i = n - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        got = actual(int'(exp_q[i].kind), int'(exp_q[i].ch));
        n_checks++;
        if (got !== exp_q[i].val) begin
          n_errors++;
          $display("FAIL %s cyc=%0d ch=%0d got=%0h exp=%0h", kname(int'(exp_q[i].kind)),
                   cyc, exp_q[i].ch, got, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_reset_view(input int unsigned at);
    exp_push(at, K_CLKEN_V, 0, 16'b01101);
    exp_push(at, K_ISO_V,   0, 16'b10010);
    exp_push(at, K_BUSY,    0, 16'd0);
    exp_push(at, K_STATE,   1, 16'd3);
    exp_push(at, K_STATE,   4, 16'd3);
    exp_push(at, K_STATE,   0, 16'd0);
    for (int c = 0; c < N; c++) exp_push(at, K_TMO, c, 16'd0);
  endtask

  int unsigned b, c, d, e;

  initial begin
    // Reset: hold the reset-gated channels' request so they stay gated.
    rst_ni   = 1'b0;
    gate_req = 5'b10010;
    idle     = 5'b11111;
    step(2);
    rst_ni = 1'b1;
    push_reset_view(cyc);
    push_reset_view(cyc + 1);
    step(2);

    // Gate channel 0 with a constantly idle cluster.
    b = cyc;
    gate_req[0] = 1'b1;
    exp_push(b,     K_ISO,   0, 16'd0);
    exp_push(b + 1, K_ISO,   0, 16'd1);
    exp_push(b + 1, K_STATE, 0, 16'd1);
    exp_push(b + 2, K_STATE, 0, 16'd2);
    exp_push(b + 2, K_BUSY,  0, 16'd1);
    exp_push(b + 5, K_CLKEN, 0, 16'd1);
    exp_push(b + 6, K_CLKEN, 0, 16'd0);
    exp_push(b + 6, K_STATE, 0, 16'd3);
    exp_push(b + 6, K_STATE, 2, 16'd0);
    exp_push(b + 6, K_STATE, 3, 16'd0);
    exp_push(b + 6, K_CLKEN_V, 0, 16'b01100);
    exp_push(b + 6, K_ISO_V,   0, 16'b10011);
    exp_push(b + 6, K_BUSY,  0, 16'd0);
    step(7);

    // Channel 2: idle drops for one cycle in SETTLE, count restarts.
    b = cyc;
    gate_req[2] = 1'b1;
    for (int k = 1; k <= 8; k++) exp_push(b + k, K_CLKEN, 2, 16'd1);
    exp_push(b + 3, K_STATE, 2, 16'd2);
    exp_push(b + 4, K_STATE, 2, 16'd1);
    exp_push(b + 5, K_STATE, 2, 16'd2);
    exp_push(b + 8, K_STATE, 2, 16'd2);
    exp_push(b + 9, K_CLKEN, 2, 16'd0);
    exp_push(b + 9, K_STATE, 2, 16'd3);
    step(3);
    idle[2] = 1'b0;
    step(1);
    idle[2] = 1'b1;
    step(6);

    // Wake channels 1 and 4; channel 4 re-requests during WAKE.
    b = cyc;
    gate_req[1] = 1'b0;
    gate_req[4] = 1'b0;
    exp_push(b,     K_CLKEN, 1, 16'd0);
    exp_push(b + 1, K_CLKEN, 1, 16'd1);
    exp_push(b + 1, K_STATE, 1, 16'd4);
    exp_push(b + 8, K_ISO,   1, 16'd1);
    exp_push(b + 9, K_ISO,   1, 16'd0);
    exp_push(b + 9, K_STATE, 1, 16'd0);
    exp_push(b + 1, K_CLKEN, 4, 16'd1);
    exp_push(b + 8, K_ISO,   4, 16'd1);
    exp_push(b + 8, K_STATE, 4, 16'd4);
    exp_push(b + 9, K_ISO,   4, 16'd0);
    exp_push(b + 9, K_STATE, 4, 16'd0);
    exp_push(b + 10, K_STATE, 4, 16'd1);
    exp_push(b + 15, K_CLKEN, 4, 16'd0);
    exp_push(b + 15, K_STATE, 4, 16'd3);
    step(3);
    gate_req[4] = 1'b1;
    step(6);
    // Channel 1 abort in SETTLE with cnt=2.
    c = cyc;
    gate_req[1] = 1'b1;
    for (int k = 1; k <= 4; k++) exp_push(c + k, K_CLKEN, 1, 16'd1);
    exp_push(c + 1, K_STATE, 1, 16'd1);
    exp_push(c + 3, K_STATE, 1, 16'd2);
    exp_push(c + 4, K_STATE, 1, 16'd0);
    exp_push(c + 4, K_ISO,   1, 16'd0);
    step(3);
    gate_req[1] = 1'b0;
    step(4);

    // Reset asserted mid-WAKE on channel 1.
    d = cyc;
    gate_req[1] = 1'b1;
    exp_push(d + 6, K_STATE, 1, 16'd3);
    exp_push(d + 8, K_STATE, 1, 16'd4);
    step(6);
    gate_req[1] = 1'b0;
    step(3);
    rst_ni   = 1'b0;
    gate_req = 5'b10010;
    push_reset_view(cyc);
    step(2);
    rst_ni = 1'b1;
    push_reset_view(cyc + 1);
    step(2);

    // Drain timeout on channel 3 with a never-idle cluster.
    e = cyc;
    idle[3]     = 1'b0;
    gate_req[3] = 1'b1;
    exp_push(e + 1, K_STATE, 3, 16'd1);
`ifdef CHIMERA_CLK_CTRL_TIMEOUT_EN
    exp_push(e + 16, K_STATE, 3, 16'd1);
    exp_push(e + 16, K_TMO,   3, 16'd0);
    exp_push(e + 17, K_STATE, 3, 16'd3);
    exp_push(e + 17, K_CLKEN, 3, 16'd0);
    exp_push(e + 17, K_TMO,   3, 16'd1);
    exp_push(e + 20, K_TMO,   3, 16'd1);
    exp_push(e + 21, K_STATE, 3, 16'd4);
    exp_push(e + 21, K_TMO,   3, 16'd0);
    step(20);
    gate_req[3] = 1'b0;
    step(3);
`else
    exp_push(e + 1000, K_STATE, 3, 16'd1);
    exp_push(e + 1000, K_CLKEN, 3, 16'd1);
    exp_push(e + 1000, K_TMO,   3, 16'd0);
    step(1000);
    gate_req[3] = 1'b0;
    exp_push(cyc + 1, K_STATE, 3, 16'd0);
    step(3);
`endif

    // Drain outstanding expectations with a bounded wait.
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) step(1);
    if (exp_q.size() != 0) begin
      $display("FAIL drain pending=%0d", exp_q.size());
      n_errors += exp_q.size();
      n_checks += exp_q.size();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
